lsu: RTL

//  Load-store unit for the single-cycle RV32I core; sits directly downstream of the ALU.

---
 rtl/lsu.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu - load-store unit for the single-cycle RV32I core.
// Decodes the ALU-supplied effective address into data memory or memory-mapped
// I/O, performs byte/half/word stores on the rising clock edge and produces the
// sign/zero-extended load result combinationally for writeback.  Also owns the
// output peripheral registers and the input synchronizers.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int DMEM_AW  = 11,   // data-memory word-address width (8 KiB window)
    parameter int SYNC_STG = 2     // synchronizer depth on switches / buttons
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_ld_data,
    output logic        o_misaligned,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [31:0] o_io_hexl,
    output logic [31:0] o_io_hexh,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);

    // Memory-mapped register addresses (compared at word granularity).
    localparam logic [15:0] ADDR_LEDR = 16'h7000;
    localparam logic [15:0] ADDR_LEDG = 16'h7010;
    localparam logic [15:0] ADDR_HEXL = 16'h7020;
    localparam logic [15:0] ADDR_HEXH = 16'h7024;
    localparam logic [15:0] ADDR_LCD  = 16'h7030;
    localparam logic [15:0] ADDR_SW   = 16'h7800;
    localparam logic [15:0] ADDR_BTN  = 16'h7810;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] dmem [2**DMEM_AW];

    logic [31:0] ledr_q, ledg_q, hexl_q, hexh_q, lcd_q;
    logic [31:0] sw_sync  [SYNC_STG];
    logic [3:0]  btn_sync [SYNC_STG];

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    acc_size_e          acc_size;
    logic               ld_unsigned;
    logic               misaligned;
    logic [3:0]         lane_en;
    logic [31:0]        wr_data;
    logic               wr_ok;
    logic               dmem_we;
    logic [DMEM_AW-1:0] dmem_idx;

    logic upper_zero;
    logic hit_dmem, hit_ledr, hit_ledg, hit_hexl, hit_hexh, hit_lcd, hit_sw, hit_btn;

    // Size/sign decode: stores only know B/H/W (anything else is SW); loads add BU/HU (anything else is LW).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        acc_size    = SZ_WORD;
        ld_unsigned = 1'b0;
        if (i_lsu_wren) begin
            unique case (i_funct3)
                3'b000:  acc_size = SZ_BYTE;
                3'b001:  acc_size = SZ_HALF;
                default: acc_size = SZ_WORD;
            endcase
        end else begin
            unique case (i_funct3)
                3'b000:  acc_size = SZ_BYTE;
                3'b001:  acc_size = SZ_HALF;
                3'b100: begin
                    acc_size    = SZ_BYTE;
                    ld_unsigned = 1'b1;
                end
                3'b101: begin
                    acc_size    = SZ_HALF;
                    ld_unsigned = 1'b1;
                end
                default: acc_size = SZ_WORD;
            endcase
        end
    end

    // Natural alignment check; a misaligned access neither writes nor returns data.
    always_comb begin
        unique case (acc_size)
            SZ_HALF: misaligned = i_lsu_addr[0];
            SZ_WORD: misaligned = |i_lsu_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Byte-lane enables and lane-replicated store data, shared by DMEM and output registers.
    always_comb begin
        lane_en = 4'b0000;
        wr_data = i_st_data;
        unique case (acc_size)
            SZ_BYTE: begin
                lane_en = 4'b0001 << i_lsu_addr[1:0];
                wr_data = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                lane_en = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{i_st_data[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_data = i_st_data;
            end
        endcase
    end

    // Address map: anything with a non-zero upper half is unmapped.
    always_comb begin
        upper_zero = (i_lsu_addr[31:16] == 16'h0000);
        hit_dmem   = upper_zero && (i_lsu_addr[15:13] == 3'b001);
        hit_ledr   = upper_zero && (i_lsu_addr[15:2] == ADDR_LEDR[15:2]);
        hit_ledg   = upper_zero && (i_lsu_addr[15:2] == ADDR_LEDG[15:2]);
        hit_hexl   = upper_zero && (i_lsu_addr[15:2] == ADDR_HEXL[15:2]);
        hit_hexh   = upper_zero && (i_lsu_addr[15:2] == ADDR_HEXH[15:2]);
        hit_lcd    = upper_zero && (i_lsu_addr[15:2] == ADDR_LCD[15:2]);
        hit_sw     = upper_zero && (i_lsu_addr[15:2] == ADDR_SW[15:2]);
        hit_btn    = upper_zero && (i_lsu_addr[15:2] == ADDR_BTN[15:2]);
    end

    assign dmem_idx = i_lsu_addr[DMEM_AW+1:2];
    assign wr_ok    = i_lsu_wren && !misaligned;
    // A store coincident with reset must not land in memory either.
    assign dmem_we  = wr_ok && hit_dmem && !i_rst;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  en);
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = en[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Data memory write port
    // ------------------------------------------------------------------
    // Byte-lane write into the addressed DMEM word.
    always_ff @(posedge i_clk) begin
        // NOTE: the memory array has no reset branch so it maps onto block RAM; its contents survive reset.
        if (dmem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) begin
                    dmem[dmem_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output peripheral registers
    // ------------------------------------------------------------------
    // Output registers take the same byte-lane writes as DMEM; reset clears them immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            ledr_q <= '0;
            ledg_q <= '0;
            hexl_q <= '0;
            hexh_q <= '0;
            lcd_q  <= '0;
        end else if (wr_ok) begin
            if (hit_ledr) ledr_q <= merge_lanes(ledr_q, wr_data, lane_en);
            if (hit_ledg) ledg_q <= merge_lanes(ledg_q, wr_data, lane_en);
            if (hit_hexl) hexl_q <= merge_lanes(hexl_q, wr_data, lane_en);
            if (hit_hexh) hexh_q <= merge_lanes(hexh_q, wr_data, lane_en);
            if (hit_lcd)  lcd_q  <= merge_lanes(lcd_q,  wr_data, lane_en);
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_hexl = hexl_q;
    assign o_io_hexh = hexh_q;
    assign o_io_lcd  = lcd_q;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    // SYNC_STG-deep flop chain per switch/button bit; the last stage is what loads see.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int s = 0; s < SYNC_STG; s++) begin
                sw_sync[s]  <= '0;
                btn_sync[s] <= '0;
            end
        end else begin
            sw_sync[0]  <= i_io_sw;
            btn_sync[0] <= i_io_btn;
            for (int s = 1; s < SYNC_STG; s++) begin
                sw_sync[s]  <= sw_sync[s-1];
                btn_sync[s] <= btn_sync[s-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] rd_shift;

    // Select the addressed word, then extract and extend the requested lane(s).
    always_comb begin
        rd_word = '0;
        if (hit_dmem)      rd_word = dmem[dmem_idx];
        else if (hit_ledr) rd_word = ledr_q;
        else if (hit_ledg) rd_word = ledg_q;
        else if (hit_hexl) rd_word = hexl_q;
        else if (hit_hexh) rd_word = hexh_q;
        else if (hit_lcd)  rd_word = lcd_q;
        else if (hit_sw)   rd_word = sw_sync[SYNC_STG-1];
        else if (hit_btn)  rd_word = {28'h0, btn_sync[SYNC_STG-1]};

        // Aligned halves have addr[0]=0, so a byte-granular shift serves both sizes.
        rd_shift = rd_word >> {i_lsu_addr[1:0], 3'b000};

        o_ld_data = '0;
        if (!misaligned) begin
            unique case (acc_size)
                SZ_BYTE: o_ld_data = ld_unsigned ? {24'h0, rd_shift[7:0]}
                                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
                SZ_HALF: o_ld_data = ld_unsigned ? {16'h0, rd_shift[15:0]}
                                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
                default: o_ld_data = rd_word;
            endcase
        end
    end

    assign o_misaligned = misaligned;

endmodule
